// File: rtl/int_to_float_pkg.sv
// Shared definitions for the integer/float converter family.
// Holds IEEE-754 single-precision field widths, the exponent bias, the zero
// encoding, the converter state encoding and a magnitude helper.
package int_to_float_pkg;

    localparam int unsigned MANT_W = 23;
    localparam int unsigned EXP_W  = 8;

    localparam logic [EXP_W-1:0] EXP_BIAS   = 8'd127;
    localparam logic [31:0]      FLOAT_ZERO = 32'h0000_0000;

    // Converter sequencing states; the handshake states (get/put) share their
    // encodings with the other converters.
    typedef enum logic [2:0] {
        StGetA      = 3'd0,
        StConvert0  = 3'd1,
        StNormalise = 3'd2,
        StRound     = 3'd3,
        StPack      = 3'd4,
        StPutZ      = 3'd5
    } state_e;

    // Magnitude of a two's-complement value as unsigned 32 bits.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] a);
        return a[31] ? (~a + 32'd1) : a;
    endfunction

endpackage

// File: rtl/int_to_float.sv
// int_to_float: iterative signed 32-bit integer to IEEE-754 single converter.
// One conversion in flight; normalisation shifts one bit per cycle.
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-low reset
//   input_a      - signed integer operand
//   input_a_stb  - operand valid
//   input_a_ack  - ready for an operand (registered)
//   output_z     - IEEE-754 single result, held while output_z_stb is high
//   output_z_stb - result valid
//   output_z_ack - consumer accept
module int_to_float
    import int_to_float_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] z_q;
    logic [31:0] v_q;
    logic [23:0] m_q;
    logic [5:0]  e_q;
    logic        s_q;
    logic        g_q;
    logic        r_q;
    logic        st_q;
    logic        input_a_ack_q;
    logic        output_z_stb_q;
    logic [31:0] output_z_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StGetA;
            input_a_ack_q  <= 1'b0;
            output_z_stb_q <= 1'b0;
        end else begin
            unique case (state_q)
                StGetA: begin
                    input_a_ack_q <= 1'b1;
                    if (input_a_stb && input_a_ack_q) begin
                        a_q           <= input_a;
                        input_a_ack_q <= 1'b0;
                        state_q       <= StConvert0;
                    end
                end

                StConvert0: begin
                    if (a_q == 32'd0) begin
                        z_q     <= FLOAT_ZERO;
                        state_q <= StPutZ;
                    end else begin
                        s_q     <= a_q[31];
                        v_q     <= abs32(a_q);
                        e_q     <= 6'd31;
                        state_q <= StNormalise;
                    end
                end

                StNormalise: begin
                    if (!v_q[31]) begin
                        v_q <= v_q << 1;
                        e_q <= e_q - 6'd1;
                    end else begin
                        // Keep 24 mantissa bits; guard, round and sticky come from the rest.
                        m_q     <= v_q[31:8];
                        g_q     <= v_q[7];
                        r_q     <= v_q[6];
                        st_q    <= |v_q[5:0];
                        state_q <= StRound;
                    end
                end

                StRound: begin
                    if (ROUND_EN && g_q && (r_q || st_q || m_q[0])) begin
                        if (m_q == 24'hFF_FFFF) begin
                            // Mantissa overflow: renormalise into the next binade.
                            m_q <= 24'h80_0000;
                            e_q <= e_q + 6'd1;
                        end else begin
                            m_q <= m_q + 24'd1;
                        end
                    end
                    state_q <= StPack;
                end

                StPack: begin
                    z_q     <= {s_q, EXP_BIAS + {2'b00, e_q}, m_q[MANT_W-1:0]};
                    state_q <= StPutZ;
                end

                StPutZ: begin
                    output_z_stb_q <= 1'b1;
                    output_z_q     <= z_q;
                    if (output_z_stb_q && output_z_ack) begin
                        output_z_stb_q <= 1'b0;
                        state_q        <= StGetA;
                    end
                end

                default: begin
                    state_q <= StGetA;
                end
            endcase
        end
    end

    assign input_a_ack  = input_a_ack_q;
    assign output_z     = output_z_q;
    assign output_z_stb = output_z_stb_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: one instance rounding to nearest even,
// one truncating. Directed vectors, backpressure, mid-conversion reset and a
// randomised pass against an independent reference model.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a1, a0, z1, z0;
    logic        a1_stb, a1_ack, z1_stb, z1_ack;
    logic        a0_stb, a0_ack, z0_stb, z0_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_float #(.ROUND_EN(1'b1)) dut_rne (
        .clk          (clk),
        .rst          (rst),
        .input_a      (a1),
        .input_a_stb  (a1_stb),
        .input_a_ack  (a1_ack),
        .output_z     (z1),
        .output_z_stb (z1_stb),
        .output_z_ack (z1_ack)
    );

    int_to_float #(.ROUND_EN(1'b0)) dut_trunc (
        .clk          (clk),
        .rst          (rst),
        .input_a      (a0),
        .input_a_stb  (a0_stb),
        .input_a_ack  (a0_ack),
        .output_z     (z0),
        .output_z_stb (z0_stb),
        .output_z_ack (z0_ack)
    );

    // Reference: locate the MSB, keep 24 bits, round on the exact remainder.
    function automatic logic [31:0] ref_conv(input logic [31:0] val, input bit rnd);
        logic [31:0] mag;
        logic [63:0] q, rem, half;
        logic [7:0]  ex;
        int          p, d;
        if (val == 32'd0) return 32'd0;
        mag = val[31] ? (32'd0 - val) : val;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        if (p <= 23) begin
            q = 64'(mag) << (23 - p);
        end else begin
            d    = p - 23;
            q    = 64'(mag) >> d;
            rem  = 64'(mag) & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            if (rnd && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        ex = 8'(p + 127);
        return {val[31], ex, q[22:0]};
    endfunction

    // Full handshake on one instance; returns result and stb latency in cycles.
    task automatic do_conv(input bit sel, input logic [31:0] val, input int ack_gap,
                           output logic [31:0] res, output int lat);
        int n = 0;
        while (!(sel ? a1_ack : a0_ack) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL in_ack_timeout: input_a_ack low for %0d cycles, required high", n);
        end
        if (sel) begin a1 = val; a1_stb = 1'b1; end
        else     begin a0 = val; a0_stb = 1'b1; end
        @(posedge clk); #1;
        if (sel) a1_stb = 1'b0; else a0_stb = 1'b0;
        lat = 0;
        while (!(sel ? z1_stb : z0_stb) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 100) begin
            checks++; errors++;
            $display("FAIL out_stb_timeout: output_z_stb low for %0d cycles for a=%h", lat, val);
        end
        res = sel ? z1 : z0;
        for (int i = 0; i < ack_gap; i++) begin
            @(posedge clk); #1;
        end
        if (sel) z1_ack = 1'b1; else z0_ack = 1'b1;
        @(posedge clk); #1;
        if (sel) z1_ack = 1'b0; else z0_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a1 = '0; a0 = '0;
        a1_stb = 1'b0; a0_stb = 1'b0; z1_ack = 1'b0; z0_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a1_ack !== 1'b0) begin
            errors++; $display("FAIL reset_in_ack: got %b, required 0", a1_ack);
        end
        checks++;
        if (z1_stb !== 1'b0) begin
            errors++; $display("FAIL reset_out_stb: got %b, required 0", z1_stb);
        end
        checks++;
        if (z0_stb !== 1'b0 || a0_ack !== 1'b0) begin
            errors++; $display("FAIL reset_trunc: stb=%b ack=%b, required 0 0", z0_stb, a0_ack);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a1_ack !== 1'b1) begin
            errors++; $display("FAIL reset_release_ack: got %b, required 1", a1_ack);
        end
    endtask

    task automatic test_vec(input string name, input bit sel, input logic [31:0] val,
                            input logic [31:0] exp_z, input int exp_lat);
        logic [31:0] r;
        int          l;
        do_conv(sel, val, 0, r, l);
        checks++;
        if (r !== exp_z) begin
            errors++; $display("FAIL %s: a=%h got %h, required %h", name, val, r, exp_z);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (l != exp_lat) begin
                errors++; $display("FAIL %s_latency: got %0d, required %0d", name, l, exp_lat);
            end
        end
    endtask

    task automatic test_zero_unity();
        test_vec("zero",      1'b1, 32'h0000_0000, 32'h0000_0000, 2);
        test_vec("plus_one",  1'b1, 32'h0000_0001, 32'h3F80_0000, 36);
        test_vec("minus_one", 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 36);
    endtask

    task automatic test_extremes();
        test_vec("int_min", 1'b1, 32'h8000_0000, 32'hCF00_0000, 5);
        test_vec("int_max", 1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 6);
    endtask

    task automatic test_tie_even();
        test_vec("tie_down", 1'b1, 32'h0100_0001, 32'h4B80_0000, -1);
        test_vec("tie_up",   1'b1, 32'h0100_0003, 32'h4B80_0002, -1);
        test_vec("tie_neg",  1'b1, 32'hFEFF_FFFF, 32'hCB80_0000, -1);
    endtask

    task automatic test_truncate();
        test_vec("trunc_max", 1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 6);
        test_vec("trunc_odd", 1'b0, 32'h0100_0003, 32'h4B80_0001, -1);
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        int          n = 0;
        while (!a1_ack && n < 100) begin @(posedge clk); #1; n++; end
        a1 = 32'h0000_0003; a1_stb = 1'b1;
        @(posedge clk); #1;
        a1_stb = 1'b0;
        n = 0;
        while (!z1_stb && n < 100) begin @(posedge clk); #1; n++; end
        first = z1;
        checks++;
        if (first !== 32'h4040_0000) begin
            errors++; $display("FAIL bp_value: got %h, required 40400000", first);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (z1_stb !== 1'b1 || z1 !== 32'h4040_0000 || a1_ack !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: stb=%b z=%h in_ack=%b, required 1 40400000 0",
                         i, z1_stb, z1, a1_ack);
            end
        end
        z1_ack = 1'b1;
        @(posedge clk); #1;
        z1_ack = 1'b0;
        checks++;
        if (z1_stb !== 1'b0 || a1_ack !== 1'b0) begin
            errors++; $display("FAIL bp_release: stb=%b in_ack=%b, required 0 0", z1_stb, a1_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (a1_ack !== 1'b1) begin
            errors++; $display("FAIL bp_ready: in_ack=%b, required 1", a1_ack);
        end
    endtask

    task automatic test_reset_mid();
        int          n = 0;
        bit          seen = 1'b0;
        logic [31:0] r;
        int          l;
        while (!a1_ack && n < 100) begin @(posedge clk); #1; n++; end
        a1 = 32'h0000_0001; a1_stb = 1'b1;
        @(posedge clk); #1;
        a1_stb = 1'b0;
        // Two edges later the instance is shifting in the normalise state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (a1_ack !== 1'b0 || z1_stb !== 1'b0) begin
            errors++; $display("FAIL mid_reset: in_ack=%b stb=%b, required 0 0", a1_ack, z1_stb);
        end
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (z1_stb) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mid_reset_drop: result emitted=1, required 0");
        end
        do_conv(1'b1, 32'h0000_0002, 0, r, l);
        checks++;
        if (r !== 32'h4000_0000) begin
            errors++; $display("FAIL mid_reset_next: got %h, required 40000000", r);
        end
    endtask

    task automatic test_random();
        logic [31:0] v, r, e;
        int          l;
        for (int k = 0; k < 600; k++) begin
            bit sel = k[0];
            v = $urandom;
            v = v >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
            if ($urandom_range(0, 49) == 0) v = 32'd0;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                @(posedge clk); #1;
            end
            e = ref_conv(v, sel);
            do_conv(sel, v, int'($urandom_range(0, 3)), r, l);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random[%0d] round=%0d: a=%h got %h, required %h", k, sel, v, r, e);
            end
            checks++;
            if ((sel ? z1_stb : z0_stb) !== 1'b0) begin
                errors++; $display("FAIL random_dup[%0d]: stb=1 after accept, required 0", k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_unity();
        test_extremes();
        test_tie_even();
        test_truncate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
